// File: rtl/amt_recovery_sequencer.sv
// amt_recovery_sequencer: walks the AMT in COMMIT_WIDTH groups after a recovery, driving RMT lane write enables
module amt_recovery_sequencer #(
  parameter int SIZE_RMT     = 34,
  parameter int SIZE_RMT_LOG = 6,
  parameter int COMMIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    recoverFlag_i,
  input  logic                    rmtReady_i,
  output logic [SIZE_RMT_LOG-1:0] rdBase_o,
  output logic [3:0]              rmtWe_o,
  output logic                    busy_o,
  output logic                    stallCommit_o,
  output logic                    done_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [SIZE_RMT_LOG:0] SIZE = (SIZE_RMT_LOG+1)'(SIZE_RMT);
  logic [1:0]              state;
  logic [SIZE_RMT_LOG-1:0] base;
  logic [SIZE_RMT_LOG:0]   next_base;
  logic                    walk;
  logic                    last;
  assign walk      = state == WALK;
  // one extra bit so base+COMMIT_WIDTH past the top entry cannot wrap before the compare
  assign next_base = {1'b0, base} + (SIZE_RMT_LOG+1)'(COMMIT_WIDTH);
  assign last      = next_base >= SIZE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= recoverFlag_i ? WALK : walk && rmtReady_i && last ? DONE : walk ? WALK : IDLE;
      base  <= recoverFlag_i ? '0 : walk && rmtReady_i ? (last ? '0 : next_base[SIZE_RMT_LOG-1:0]) : base;
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign rmtWe_o[g] = walk && rmtReady_i && (({1'b0, base} + (SIZE_RMT_LOG+1)'(g)) < SIZE);
  end
  assign rdBase_o      = base;
  assign busy_o        = walk || state == DONE;
  assign stallCommit_o = busy_o;
  assign done_o        = state == DONE;
endmodule
